// File: rtl/mem_ctrl_if.sv
// Requester and RAM-port bundle for mem_ctrl: fetcher fills, LSB loads/stores and the byte-wide RAM/IO port.
// The slave modport is the controller's view; master is the environment's view.
interface mem_ctrl_if;
  logic        fet_mem_enable;
  logic [31:0] fet_mem_addr;
  logic        lsb_mem_enable;
  logic        lsb_mem_we;
  logic [1:0]  lsb_mem_width;
  logic [31:0] lsb_mem_addr;
  logic [31:0] lsb_mem_data;
  logic        io_buffer_full;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        mem_inst_ready;
  logic [31:0] mem_inst;
  logic [31:0] mem_inst_addr;
  logic        mem_data_ready;
  logic [31:0] mem_data;

  modport slave (
    input  fet_mem_enable, fet_mem_addr,
    input  lsb_mem_enable, lsb_mem_we, lsb_mem_width, lsb_mem_addr, lsb_mem_data,
    input  io_buffer_full, mem_din,
    output mem_dout, mem_a, mem_wr,
    output mem_inst_ready, mem_inst, mem_inst_addr,
    output mem_data_ready, mem_data
  );

  modport master (
    output fet_mem_enable, fet_mem_addr,
    output lsb_mem_enable, lsb_mem_we, lsb_mem_width, lsb_mem_addr, lsb_mem_data,
    output io_buffer_full, mem_din,
    input  mem_dout, mem_a, mem_wr,
    input  mem_inst_ready, mem_inst, mem_inst_addr,
    input  mem_data_ready, mem_data
  );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates fetcher fills against LSB loads/stores and
// sequences them one byte per cycle over the single RAM port.
module mem_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy,
  input  logic       flush,
  mem_ctrl_if.slave  bus
);
  localparam int XLEN = 32;

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
  typedef enum logic {OWN_INST = 1'b0, OWN_DATA = 1'b1} owner_t;

  state_t          state, state_n;
  owner_t          owner, last_grant, grant_owner;
  logic [2:0]      len, len_req, rd_len;
  logic [1:0]      ia, ca;
  logic            primed;
  logic [XLEN-1:0] base, wdata, asm_q, asm_n, next_a;
  logic [7:0]      next_byte;
  logic            data_ok, grant, rd_issue, rd_last, wr_last;

  always_comb begin
    state_n     = state;
    grant       = 1'b0;
    grant_owner = OWN_INST;
    // stores to the UART window wait while its buffer is full
    data_ok = bus.lsb_mem_enable &&
              !(bus.lsb_mem_we && bus.lsb_mem_addr[17:16] == 2'b11 && bus.io_buffer_full);
    case (bus.lsb_mem_width)
      2'b00:   len_req = 3'd1;
      2'b01:   len_req = 3'd2;
      default: len_req = 3'd4;
    endcase
    // a fill whose first halfword is compressed stops after two bytes
    rd_len = len;
    if (owner == OWN_INST && ca == 2'd0 && bus.mem_din[1:0] != 2'b11)
      rd_len = 3'd2;
    rd_issue  = ({1'b0, ia} < len - 3'd1);
    rd_last   = primed && ({1'b0, ca} == rd_len - 3'd1);
    wr_last   = ({1'b0, ia} == len - 3'd1);
    next_a    = base + {30'd0, ia} + 32'd1;
    next_byte = wdata[{ia + 2'd1, 3'b000} +: 8];
    asm_n     = asm_q;
    asm_n[{ca, 3'b000} +: 8] = bus.mem_din;
    case (state)
      IDLE: begin
        if (!flush && (bus.fet_mem_enable || data_ok)) begin
          grant       = 1'b1;
          grant_owner = (data_ok && (!bus.fet_mem_enable || last_grant == OWN_INST))
                        ? OWN_DATA : OWN_INST;
          state_n     = (grant_owner == OWN_DATA && bus.lsb_mem_we) ? WRITE : READ;
        end
      end
      READ:    if (flush || rd_last) state_n = IDLE;
      WRITE:   if (wr_last) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)      state <= IDLE;
    else if (rdy) state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner              <= OWN_INST;
      last_grant         <= OWN_INST;
      len                <= 3'd0;
      ia                 <= 2'd0;
      ca                 <= 2'd0;
      primed             <= 1'b0;
      base               <= '0;
      wdata              <= '0;
      asm_q              <= '0;
      bus.mem_a          <= '0;
      bus.mem_dout       <= 8'h00;
      bus.mem_wr         <= 1'b0;
      bus.mem_inst_ready <= 1'b0;
      bus.mem_inst       <= '0;
      bus.mem_inst_addr  <= '0;
      bus.mem_data_ready <= 1'b0;
      bus.mem_data       <= '0;
    end else if (rdy) begin
      bus.mem_inst_ready <= 1'b0;
      bus.mem_data_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            owner      <= grant_owner;
            last_grant <= grant_owner;
            ia         <= 2'd0;
            ca         <= 2'd0;
            primed     <= 1'b0;
            asm_q      <= '0;
            wdata      <= bus.lsb_mem_data;
            if (grant_owner == OWN_DATA) begin
              base      <= bus.lsb_mem_addr;
              len       <= len_req;
              bus.mem_a <= bus.lsb_mem_addr;
            end else begin
              base      <= bus.fet_mem_addr;
              len       <= 3'd4;
              bus.mem_a <= bus.fet_mem_addr;
            end
            if (state_n == WRITE) begin
              bus.mem_dout <= bus.lsb_mem_data[7:0];
              bus.mem_wr   <= 1'b1;
            end else begin
              bus.mem_wr   <= 1'b0;
            end
          end
        end
        READ: begin
          if (flush) begin
            bus.mem_a <= '0;
          end else begin
            // first byte appears on mem_din two edges after accept
            primed <= 1'b1;
            if (rd_issue) begin
              ia        <= ia + 2'd1;
              bus.mem_a <= next_a;
            end
            if (primed) begin
              asm_q <= asm_n;
              ca    <= ca + 2'd1;
              len   <= rd_len;
              if (rd_last) begin
                bus.mem_a <= '0;
                if (owner == OWN_INST) begin
                  bus.mem_inst_ready <= 1'b1;
                  bus.mem_inst       <= asm_n;
                  bus.mem_inst_addr  <= base;
                end else begin
                  bus.mem_data_ready <= 1'b1;
                  bus.mem_data       <= asm_n;
                end
              end
            end
          end
        end
        WRITE: begin
          if (wr_last) begin
            bus.mem_wr         <= 1'b0;
            bus.mem_a          <= '0;
            bus.mem_dout       <= 8'h00;
            bus.mem_data_ready <= 1'b1;
          end else begin
            ia           <= ia + 2'd1;
            bus.mem_a    <= next_a;
            bus.mem_dout <= next_byte;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: byte RAM model, scoreboard queues for fills, loads and written bytes.
module tb_mem_ctrl;
  logic clk = 1'b0;
  logic rst, rdy, flush;
  mem_ctrl_if m();

  mem_ctrl u_dut (.clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .bus(m.slave));

  always #5 clk = ~clk;

  typedef struct packed {logic [31:0] a; logic [31:0] d;} pair_t;
  typedef struct packed {logic ld; logic [31:0] d;} dexp_t;

  pair_t       inst_q[$];
  pair_t       w_q[$];
  dexp_t       d_q[$];
  logic [31:0] a_log[$];
  logic [7:0]  ram [logic [31:0]];
  int          n_vec = 0;
  int          n_err = 0;
  int          edges;

  function automatic logic [7:0] rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction

  always @(posedge clk) m.mem_din <= rd(m.mem_a);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // scoreboard pops on every ready pulse and every written byte
  always @(negedge clk) begin
    pair_t p;
    dexp_t e;
    if (m.mem_inst_ready === 1'b1) begin
      chk("inst_ready_expected", 32'(inst_q.size() != 0), 32'd1);
      if (inst_q.size() != 0) begin
        p = inst_q.pop_front();
        chk("mem_inst", m.mem_inst, p.d);
        chk("mem_inst_addr", m.mem_inst_addr, p.a);
      end
    end
    if (m.mem_data_ready === 1'b1) begin
      chk("data_ready_expected", 32'(d_q.size() != 0), 32'd1);
      if (d_q.size() != 0) begin
        e = d_q.pop_front();
        if (e.ld) chk("mem_data", m.mem_data, e.d);
      end
    end
    if (m.mem_wr === 1'b1) begin
      chk("write_expected", 32'(w_q.size() != 0), 32'd1);
      if (w_q.size() != 0) begin
        p = w_q.pop_front();
        chk("wr_addr", m.mem_a, p.a);
        chk("wr_byte", {24'd0, m.mem_dout}, p.d);
      end
    end
  end

  // counts negedges until the selected ready pulse; -1 if it never comes
  task automatic wait_rdy(input bit inst, input int fl_at, input int lo_a, input int lo_b,
                          output int n);
    bit done = 1'b0;
    n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
      a_log.push_back(m.mem_a);
      done = inst ? m.mem_inst_ready : m.mem_data_ready;
      flush = !done && (n == fl_at);
      rdy   = done || !(n >= lo_a && n < lo_b);
    end
    flush = 1'b0;
    rdy   = 1'b1;
    if (!done) n = -1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_a"}, m.mem_a, 32'd0);
    chk({tag, "_mem_dout"}, {24'd0, m.mem_dout}, 32'd0);
    chk({tag, "_mem_wr"}, {31'd0, m.mem_wr}, 32'd0);
    chk({tag, "_inst_ready"}, {31'd0, m.mem_inst_ready}, 32'd0);
    chk({tag, "_data_ready"}, {31'd0, m.mem_data_ready}, 32'd0);
    chk({tag, "_mem_inst"}, m.mem_inst, 32'd0);
    chk({tag, "_mem_inst_addr"}, m.mem_inst_addr, 32'd0);
    chk({tag, "_mem_data"}, m.mem_data, 32'd0);
  endtask

  initial begin
    ram[32'h1000] = 8'h13; ram[32'h1001] = 8'h05; ram[32'h1002] = 8'h00; ram[32'h1003] = 8'h00;
    ram[32'h2002] = 8'h01; ram[32'h2003] = 8'h45; ram[32'h2004] = 8'h77; ram[32'h2005] = 8'h88;
    ram[32'h0040] = 8'hFF; ram[32'h0041] = 8'h80;
    ram[32'h0200] = 8'h11; ram[32'h0201] = 8'h22; ram[32'h0202] = 8'h33; ram[32'h0203] = 8'h44;
    rst = 1'b1; rdy = 1'b1; flush = 1'b0;
    m.fet_mem_enable = 1'b0; m.fet_mem_addr = '0;
    m.lsb_mem_enable = 1'b0; m.lsb_mem_we = 1'b0; m.lsb_mem_width = 2'b00;
    m.lsb_mem_addr = '0; m.lsb_mem_data = '0; m.io_buffer_full = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // tie after reset: 4-byte store wins, fill follows on the edge after the store's ready
    m.fet_mem_enable = 1'b1; m.fet_mem_addr = 32'h1000;
    m.lsb_mem_enable = 1'b1; m.lsb_mem_we = 1'b1; m.lsb_mem_width = 2'b10;
    m.lsb_mem_addr = 32'h100; m.lsb_mem_data = 32'hA1B2C3D4;
    w_q.push_back('{32'h100, 32'hD4}); w_q.push_back('{32'h101, 32'hC3});
    w_q.push_back('{32'h102, 32'hB2}); w_q.push_back('{32'h103, 32'hA1});
    d_q.push_back('{1'b0, 32'd0});
    inst_q.push_back('{32'h1000, 32'h00000513});
    wait_rdy(1'b0, 0, 0, 0, edges);
    chk("tie_store_lat", edges, 5);
    chk("tie_store_bytes_left", w_q.size(), 0);
    chk("tie_inst_pending", inst_q.size(), 1);
    m.lsb_mem_enable = 1'b0;
    wait_rdy(1'b1, 0, 0, 0, edges);
    chk("tie_fill_lat", edges, 6);
    m.fet_mem_enable = 1'b0;
    @(negedge clk);

    // plain 4-byte fill
    m.fet_mem_enable = 1'b1; m.fet_mem_addr = 32'h1000;
    inst_q.push_back('{32'h1000, 32'h00000513});
    wait_rdy(1'b1, 0, 0, 0, edges);
    chk("fill4_lat", edges, 6);
    chk("fill4_mem_a_after", m.mem_a, 32'd0);
    m.fet_mem_enable = 1'b0;
    @(negedge clk);

    // compressed fill stops after two bytes
    m.fet_mem_enable = 1'b1; m.fet_mem_addr = 32'h2002;
    inst_q.push_back('{32'h2002, 32'h00004501});
    a_log.delete();
    wait_rdy(1'b1, 0, 0, 0, edges);
    chk("fillc_lat", edges, 4);
    if (a_log.size() == 4) begin
      chk("fillc_a0", a_log[0], 32'h2002);
      chk("fillc_a1", a_log[1], 32'h2003);
      chk("fillc_a2", a_log[2], 32'h2004);
      chk("fillc_a3", a_log[3], 32'h0);
    end
    m.fet_mem_enable = 1'b0;
    @(negedge clk);

    // rdy low for two edges stretches a 4-byte fill by two
    m.fet_mem_enable = 1'b1; m.fet_mem_addr = 32'h1000;
    inst_q.push_back('{32'h1000, 32'h00000513});
    wait_rdy(1'b1, 0, 1, 3, edges);
    chk("fill_rdy_lat", edges, 8);
    m.fet_mem_enable = 1'b0;
    @(negedge clk);

    // loads: halfword, byte, word
    m.lsb_mem_enable = 1'b1; m.lsb_mem_we = 1'b0; m.lsb_mem_width = 2'b01; m.lsb_mem_addr = 32'h40;
    d_q.push_back('{1'b1, 32'h000080FF});
    wait_rdy(1'b0, 0, 0, 0, edges);
    chk("ld_half_lat", edges, 4);
    m.lsb_mem_enable = 1'b0;
    @(negedge clk);
    m.lsb_mem_enable = 1'b1; m.lsb_mem_width = 2'b00; m.lsb_mem_addr = 32'h41;
    d_q.push_back('{1'b1, 32'h00000080});
    wait_rdy(1'b0, 0, 0, 0, edges);
    chk("ld_byte_lat", edges, 3);
    m.lsb_mem_enable = 1'b0;
    @(negedge clk);
    m.lsb_mem_enable = 1'b1; m.lsb_mem_width = 2'b10; m.lsb_mem_addr = 32'h200;
    d_q.push_back('{1'b1, 32'h44332211});
    wait_rdy(1'b0, 0, 0, 0, edges);
    chk("ld_word_lat", edges, 6);
    m.lsb_mem_enable = 1'b0;
    @(negedge clk);

    // UART store held off while io_buffer_full
    m.lsb_mem_enable = 1'b1; m.lsb_mem_we = 1'b1; m.lsb_mem_width = 2'b00;
    m.lsb_mem_addr = 32'h30000; m.lsb_mem_data = 32'h0000005A; m.io_buffer_full = 1'b1;
    w_q.push_back('{32'h30000, 32'h5A});
    d_q.push_back('{1'b0, 32'd0});
    repeat (3) begin
      @(negedge clk);
      chk("io_hold_wr", {31'd0, m.mem_wr}, 32'd0);
    end
    m.io_buffer_full = 1'b0;
    wait_rdy(1'b0, 0, 0, 0, edges);
    chk("io_store_lat", edges, 2);
    m.lsb_mem_enable = 1'b0;
    @(negedge clk);

    // flush aborts a word load while capturing byte 2
    m.lsb_mem_enable = 1'b1; m.lsb_mem_we = 1'b0; m.lsb_mem_width = 2'b10; m.lsb_mem_addr = 32'h200;
    a_log.delete();
    repeat (4) begin
      @(negedge clk);
      a_log.push_back(m.mem_a);
    end
    flush = 1'b1; m.lsb_mem_enable = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_ld_mem_a", m.mem_a, 32'd0);
    chk("flush_ld_ready", {31'd0, m.mem_data_ready}, 32'd0);
    chk("flush_ld_a3", a_log[3], 32'h203);
    repeat (4) @(negedge clk);
    chk("flush_ld_data_held", m.mem_data, 32'h44332211);

    // flush during a store is ignored
    m.lsb_mem_enable = 1'b1; m.lsb_mem_we = 1'b1; m.lsb_mem_width = 2'b10;
    m.lsb_mem_addr = 32'h300; m.lsb_mem_data = 32'h11223344;
    w_q.push_back('{32'h300, 32'h44}); w_q.push_back('{32'h301, 32'h33});
    w_q.push_back('{32'h302, 32'h22}); w_q.push_back('{32'h303, 32'h11});
    d_q.push_back('{1'b0, 32'd0});
    wait_rdy(1'b0, 1, 0, 0, edges);
    chk("flush_st_lat", edges, 5);
    chk("flush_st_bytes_left", w_q.size(), 0);
    m.lsb_mem_enable = 1'b0;
    @(negedge clk);

    // reset in the middle of a fill clears every output
    m.fet_mem_enable = 1'b1; m.fet_mem_addr = 32'h1000;
    repeat (3) @(negedge clk);
    rst = 1'b1; m.fet_mem_enable = 1'b0;
    @(negedge clk);
    chk_all_zero("rst_mid");
    rst = 1'b0;
    repeat (3) @(negedge clk);

    chk("inst_q_drained", inst_q.size(), 0);
    chk("data_q_drained", d_q.size(), 0);
    chk("wr_q_drained", w_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory controller between the byte-wide RAM/IO port and the two memory requesters: the fetcher (instruction fills that feed `icache`) and the load/store buffer (LSB). It arbitrates between them, sequences multi-byte reads and writes one byte per cycle over the single RAM port, and returns assembled results with one-cycle ready pulses. Instruction fills shorten to 2 bytes when the first halfword is compressed.

## Interface
- Parameters: none; widths come from `global_params.v` (`XLEN` = 32).
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `rdy` in 1: global enable; when low, all state and outputs hold.
- `flush` in 1: misprediction flush.
- `fet_mem_enable` in 1: instruction fill request; held until `mem_inst_ready` or `flush`.
- `fet_mem_addr` in 32: fill address, halfword aligned.
- `lsb_mem_enable` in 1: data request; held until `mem_data_ready`.
- `lsb_mem_we` in 1: 1 = store, 0 = load.
- `lsb_mem_width` in 2: byte count selector; 00 = 1 byte, 01 = 2 bytes, 10 = 4 bytes.
- `lsb_mem_addr` in 32: data address.
- `lsb_mem_data` in 32: store data, little-endian.
- `io_buffer_full` in 1: UART buffer full.
- `mem_din` in 8: RAM read byte.
- `mem_dout` out 8: RAM write byte.
- `mem_a` out 32: RAM address.
- `mem_wr` out 1: 1 = write.
- `mem_inst_ready` out 1: one-cycle pulse; fill done.
- `mem_inst` out 32: fill data; upper 16 bits are 0 for a compressed fill.
- `mem_inst_addr` out 32: address of the returned fill.
- `mem_data_ready` out 1: one-cycle pulse; load or store done.
- `mem_data` out 32: load data, zero-extended; sign extension is done in the LSB.

## Operation
- States: IDLE, READ, WRITE.
- Registers: `owner` (INST/DATA), `last_grant`, `len` (1/2/4), issue index `ia`, capture index `ca`, `base` address, byte assembly register.

Arbitration (in IDLE):
- When only one request is pending, grant it.
- When both are pending, grant the one that did not receive the previous grant (`last_grant`). After reset, DATA wins the first tie.
- A store with `lsb_mem_addr[17:16]==2'b11` while `io_buffer_full` is high is not granted. A pending fill may be granted in its place.

READ (fill: `len`=4; load: `len` from width):
- Accept edge: `mem_a<=base`, `mem_wr<=0`.
- Each following edge: while `ia<len-1`, `mem_a<=base+ia+1`.
- RAM latency is 1 cycle: the byte for address A, driven in cycle k, is on `mem_din` in cycle k+1. Byte i is captured at accept edge + i + 2.
- Fill early stop: when byte 0 is captured with `[1:0]!=2'b11`, `len` becomes 2. Addresses already issued are ignored.
- At the capture of the last byte: assert ready, present the assembled data, return to IDLE, and set `mem_a<=0`.

WRITE:
- Accept edge: `mem_a<=base`, `mem_dout<=data[7:0]`, `mem_wr<=1`.
- Each following edge drives the next address and byte until `len` bytes have been driven.
- On the edge after the last byte: `mem_wr<=0`, `mem_a<=0`, `mem_dout<=0`, `mem_data_ready` pulses, return to IDLE.

Flush:
- At an edge with `flush=1` in READ, the operation aborts: go to IDLE, no ready pulse, `mem_a<=0`.
- WRITE always runs to completion and its ready pulse is still issued.
- `flush` in IDLE blocks acceptance on that edge.

Reset (any state, including mid-operation):
- State goes to IDLE and `last_grant` is cleared.
- All outputs reset to 0: `mem_a`, `mem_dout`, `mem_wr`, both ready pulses, `mem_inst`, `mem_inst_addr`, `mem_data`.

## Timing
- All outputs are registered.
- The earliest accept is the first edge on which a request is seen in IDLE.
- Read latency from accept edge to ready high: 4-byte = 5 edges, 2-byte = 3, 1-byte = 2.
- Write latency from accept edge to ready high: `len` edges.
- Ready pulses last exactly one cycle (longer only while `rdy` is low).
- The earliest next accept is the edge after the ready edge, so there is one IDLE cycle between operations.
- `mem_inst`, `mem_inst_addr`, and `mem_data` hold their values until the next completion of the same owner.

## Test plan
- Fill at 0x1000, RAM bytes 13 05 00 00 → `mem_inst_ready` 5 edges after accept, `mem_inst`=0x00000513, `mem_inst_addr`=0x1000.
- Fill at 0x2002, first bytes 01 45 → 2-byte fill, ready 3 edges after accept, `mem_inst`=0x00004501; `mem_a` sequence 0x2002, 0x2003, 0x2004, then 0.
- Fill and 4-byte store at 0x100 both raised in IDLE after reset → store granted first. `mem_wr` is high for 4 cycles with bytes LSB-first, then `mem_data_ready`. The fill is accepted on the following edge.
- Byte store to 0x30000 with `io_buffer_full`=1 for 3 cycles → no `mem_wr` during those cycles; write starts on the edge after `io_buffer_full` falls.
- `flush` during a 4-byte load at capture index 2 → IDLE, no `mem_data_ready`, `mem_a`=0.
- `flush` during a store at its 2nd byte → all 4 bytes are written and `mem_data_ready` pulses.
- `rst` mid-fill → every output is 0 on the next cycle.
- Halfword load at 0x40, bytes FF 80 → `mem_data`=0x000080FF, ready 3 edges after accept.
